// File: rtl/avl_arb_pkg.sv
// Shared types and port IDs for the two-port Avalon-MM arbiter.
package avl_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic PORT_RD = 1'b0;
    localparam logic PORT_WR = 1'b1;

endpackage

// File: rtl/avalon_port_arbiter_if.sv
// Requester-side and controller-side Avalon-MM signals of the port arbiter.
interface avalon_port_arbiter_if #(
    parameter int unsigned ADDR_W = 27,
    parameter int unsigned DATA_W = 32
);
    logic              local_init_done;

    logic [ADDR_W-1:0] m0_address;
    logic [DATA_W-1:0] m0_writedata;
    logic              m0_read;
    logic              m0_write;
    logic              m0_waitrequest_n;
    logic              m0_readdatavalid;

    logic [ADDR_W-1:0] m1_address;
    logic [DATA_W-1:0] m1_writedata;
    logic              m1_read;
    logic              m1_write;
    logic              m1_waitrequest_n;
    logic              m1_readdatavalid;

    logic [DATA_W-1:0] m_readdata;

    logic [ADDR_W-1:0] avl_address;
    logic [DATA_W-1:0] avl_writedata;
    logic              avl_read;
    logic              avl_write;
    logic              avl_burstbegin;
    logic              avl_waitrequest_n;
    logic [DATA_W-1:0] avl_readdata;
    logic              avl_readdatavalid;

    logic              err_unexpected_rdv;

    // Arbiter view
    modport slave (
        input  local_init_done,
        input  m0_address, m0_writedata, m0_read, m0_write,
        input  m1_address, m1_writedata, m1_read, m1_write,
        input  avl_waitrequest_n, avl_readdata, avl_readdatavalid,
        output m0_waitrequest_n, m0_readdatavalid,
        output m1_waitrequest_n, m1_readdatavalid,
        output m_readdata,
        output avl_address, avl_writedata, avl_read, avl_write, avl_burstbegin,
        output err_unexpected_rdv
    );

    // Environment view (requesters + controller)
    modport master (
        output local_init_done,
        output m0_address, m0_writedata, m0_read, m0_write,
        output m1_address, m1_writedata, m1_read, m1_write,
        output avl_waitrequest_n, avl_readdata, avl_readdatavalid,
        input  m0_waitrequest_n, m0_readdatavalid,
        input  m1_waitrequest_n, m1_readdatavalid,
        input  m_readdata,
        input  avl_address, avl_writedata, avl_read, avl_write, avl_burstbegin,
        input  err_unexpected_rdv
    );

endinterface

// File: rtl/avl_id_fifo.sv
// In-order queue of 1-bit port IDs for outstanding reads; tolerates push+pop at full.
module avl_id_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   iCLK,
    input  logic                   iRST_n,
    input  logic                   push,
    input  logic                   push_id,
    input  logic                   pop,
    output logic                   head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rd_ptr_q];
    assign count   = cnt_q;

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_id;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/avalon_port_arbiter.sv
// Round-robin arbiter sharing one DDR3 Avalon-MM port between two requesters;
// one single-word command in flight, read returns routed back via an ID queue.
module avalon_port_arbiter
    import avl_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 27,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic                 iCLK,
    input  logic                 iRST_n,
    avalon_port_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;

    logic [DATA_W-1:0] rdata_q;
    logic              rdv0_q, rdv1_q, err_q;

    logic              rd_ok, elig0, elig1, pick1, grant, accept;
    logic              push, pop;
    logic              fifo_head, fifo_empty, fifo_full;
    logic [CNT_W-1:0]  fifo_count;

    assign rd_ok  = (fifo_count < CNT_W'(MAX_OUTST));
    assign elig0  = bus.local_init_done & (bus.m0_write | (bus.m0_read & rd_ok));
    assign elig1  = bus.local_init_done & (bus.m1_write | (bus.m1_read & rd_ok));
    assign pick1  = elig1 & (~elig0 | (last_q == PORT_RD));
    assign grant  = elig0 | elig1;
    assign accept = bus.avl_waitrequest_n & (rd_q | wr_q);
    assign pop    = bus.avl_readdatavalid & ~fifo_empty;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant)  state_d = CMD;
            CMD:     if (accept) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the command/ack registers
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    gnt_d   = pick1;
                    last_d  = pick1;
                    addr_d  = pick1 ? bus.m1_address   : bus.m0_address;
                    wdata_d = pick1 ? bus.m1_writedata : bus.m0_writedata;
                    rd_d    = pick1 ? bus.m1_read      : bus.m0_read;
                    wr_d    = pick1 ? bus.m1_write     : bus.m0_write;
                end
            end
            CMD: begin
                if (accept) begin
                    rd_d   = 1'b0;
                    wr_d   = 1'b0;
                    ack0_d = (gnt_q == PORT_RD);
                    ack1_d = (gnt_q == PORT_WR);
                    push   = rd_q & (~fifo_full | pop);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

    // Read return: route to the queued ID; empty-queue returns are dropped and flagged
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            rdata_q <= '0;
            rdv0_q  <= 1'b0;
            rdv1_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            rdv0_q <= 1'b0;
            rdv1_q <= 1'b0;
            if (pop) begin
                rdata_q <= bus.avl_readdata;
                rdv0_q  <= (fifo_head == PORT_RD);
                rdv1_q  <= (fifo_head == PORT_WR);
            end
            if (bus.avl_readdatavalid && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    avl_id_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_id_fifo (
        .iCLK    (iCLK),
        .iRST_n  (iRST_n),
        .push    (push),
        .push_id (gnt_q),
        .pop     (pop),
        .head    (fifo_head),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign bus.avl_address        = addr_q;
    assign bus.avl_writedata      = wdata_q;
    assign bus.avl_read           = rd_q;
    assign bus.avl_write          = wr_q;
    assign bus.avl_burstbegin     = rd_q | wr_q;
    assign bus.m0_waitrequest_n   = ack0_q;
    assign bus.m1_waitrequest_n   = ack1_q;
    assign bus.m_readdata         = rdata_q;
    assign bus.m0_readdatavalid   = rdv0_q;
    assign bus.m1_readdatavalid   = rdv1_q;
    assign bus.err_unexpected_rdv = err_q;

endmodule

// File: tb/tb_avalon_port_arbiter.sv
// Directed self-checking bench for avalon_port_arbiter.
module tb_avalon_port_arbiter;
    localparam int unsigned ADDR_W    = 27;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MAX_OUTST = 4;

    logic iCLK;
    logic iRST_n;
    int   checks;
    int   errors;

    avalon_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    avalon_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .bus    (bus)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic drive_req(input int port, input logic rd, input logic wr,
                             input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (port == 0) begin
            bus.m0_read = rd; bus.m0_write = wr; bus.m0_address = a; bus.m0_writedata = d;
        end else begin
            bus.m1_read = rd; bus.m1_write = wr; bus.m1_address = a; bus.m1_writedata = d;
        end
    endtask

    task automatic do_reset();
        iRST_n = 1'b0;
        tick();
        tick();
        iRST_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_avl_read"},  64'(bus.avl_read), 64'd0);
        check({tag, "_avl_write"}, 64'(bus.avl_write), 64'd0);
        check({tag, "_burst"},     64'(bus.avl_burstbegin), 64'd0);
        check({tag, "_addr"},      64'(bus.avl_address), 64'd0);
        check({tag, "_wdata"},     64'(bus.avl_writedata), 64'd0);
        check({tag, "_ack0"},      64'(bus.m0_waitrequest_n), 64'd0);
        check({tag, "_ack1"},      64'(bus.m1_waitrequest_n), 64'd0);
        check({tag, "_rdv0"},      64'(bus.m0_readdatavalid), 64'd0);
        check({tag, "_rdv1"},      64'(bus.m1_readdatavalid), 64'd0);
        check({tag, "_rdata"},     64'(bus.m_readdata), 64'd0);
        check({tag, "_err"},       64'(bus.err_unexpected_rdv), 64'd0);
    endtask

    // Issue one command with a zero-wait controller; drop the request on its ack
    task automatic issue(input int port, input logic rd, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input string tag);
        logic              seen;
        logic              seen_rd;
        logic              done;
        logic [ADDR_W-1:0] seen_addr;
        seen = 1'b0; seen_rd = 1'b0; done = 1'b0; seen_addr = '0;
        drive_req(port, rd, ~rd, a, d);
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if ((bus.avl_read || bus.avl_write) && !seen) begin
                seen = 1'b1; seen_rd = bus.avl_read; seen_addr = bus.avl_address;
            end
            if ((port == 0) ? bus.m0_waitrequest_n : bus.m1_waitrequest_n) begin
                done = 1'b1;
                drive_req(port, 1'b0, 1'b0, '0, '0);
            end
        end
        if (!done) drive_req(port, 1'b0, 1'b0, '0, '0);
        check({tag, "_ack"},  64'(done), 64'd1);
        check({tag, "_addr"}, 64'(seen_addr), 64'(a));
        check({tag, "_kind"}, 64'(seen_rd), 64'(rd));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic gp [8];
        int   gc [8];
        int   n;
        logic saw_rd, saw_wr, found;

        checks = 0;
        errors = 0;
        iRST_n = 1'b0;
        bus.local_init_done   = 1'b0;
        bus.avl_waitrequest_n = 1'b0;
        bus.avl_readdata      = '0;
        bus.avl_readdatavalid = 1'b0;
        drive_req(0, 1'b0, 1'b0, '0, '0);
        drive_req(1, 1'b0, 1'b0, '0, '0);

        // Reset state
        tick();
        check_all_zero("rst");
        tick();
        iRST_n = 1'b1;
        bus.local_init_done = 1'b1;

        // Single write stalled 3 cycles
        drive_req(1, 1'b0, 1'b1, 27'h000_0010, 32'hAA55AA55);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("wr_avl_write", 64'(bus.avl_write), 64'd1);
            check("wr_avl_addr",  64'(bus.avl_address), 64'h10);
            check("wr_avl_wdata", 64'(bus.avl_writedata), 64'hAA55AA55);
            check("wr_burst",     64'(bus.avl_burstbegin), 64'd1);
            check("wr_no_ack",    64'(bus.m1_waitrequest_n), 64'd0);
            if (i == 3) bus.avl_waitrequest_n = 1'b1;
        end
        tick();
        check("wr_ack1",       64'(bus.m1_waitrequest_n), 64'd1);
        check("wr_ack0_quiet", 64'(bus.m0_waitrequest_n), 64'd0);
        check("wr_write_clr",  64'(bus.avl_write), 64'd0);
        check("wr_burst_clr",  64'(bus.avl_burstbegin), 64'd0);
        drive_req(1, 1'b0, 1'b0, '0, '0);
        tick();
        check("wr_ack_pulse",  64'(bus.m1_waitrequest_n), 64'd0);
        check("wr_idle",       64'(bus.avl_write), 64'd0);

        // Contention from reset: alternating grants, 3 cycles apart
        do_reset();
        drive_req(0, 1'b0, 1'b1, 27'h100, 32'h0000_0100);
        drive_req(1, 1'b0, 1'b1, 27'h200, 32'h0000_0200);
        n = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            tick();
            if (bus.avl_write) begin
                gp[n] = (bus.avl_address == 27'h200);
                gc[n] = c;
                n++;
                if (n == 8) begin
                    drive_req(0, 1'b0, 1'b0, '0, '0);
                    drive_req(1, 1'b0, 1'b0, '0, '0);
                end
            end
        end
        check("cont_count", 64'(n), 64'd8);
        for (int i = 0; i < n; i++) begin
            check("cont_port", 64'(gp[i]), 64'(i % 2));
            if (i > 0) check("cont_gap", 64'(gc[i] - gc[i-1]), 64'd3);
        end
        tick();
        tick();

        // Read routing
        issue(0, 1'b1, 27'd5, '0, "rd0");
        issue(1, 1'b1, 27'd9, '0, "rd1");
        bus.avl_readdata = 32'h1111; bus.avl_readdatavalid = 1'b1;
        tick();
        check("rt_rdv0_a",  64'(bus.m0_readdatavalid), 64'd1);
        check("rt_rdv1_a",  64'(bus.m1_readdatavalid), 64'd0);
        check("rt_data_a",  64'(bus.m_readdata), 64'h1111);
        bus.avl_readdata = 32'h2222;
        tick();
        check("rt_rdv0_b",  64'(bus.m0_readdatavalid), 64'd0);
        check("rt_rdv1_b",  64'(bus.m1_readdatavalid), 64'd1);
        check("rt_data_b",  64'(bus.m_readdata), 64'h2222);
        bus.avl_readdatavalid = 1'b0;
        tick();
        check("rt_rdv_end", 64'({bus.m0_readdatavalid, bus.m1_readdatavalid}), 64'd0);
        check("rt_no_err",  64'(bus.err_unexpected_rdv), 64'd0);

        // Queue full: 5th read blocked until one return
        do_reset();
        for (int i = 0; i < 4; i++) issue(0, 1'b1, ADDR_W'(32'h40 + i), '0, "fill");
        drive_req(0, 1'b1, 1'b0, 27'h55, '0);
        drive_req(1, 1'b0, 1'b1, 27'h77, 32'h7777);
        saw_rd = 1'b0; saw_wr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.avl_read) saw_rd = 1'b1;
            if (bus.avl_write && bus.avl_address == 27'h77) saw_wr = 1'b1;
            if (bus.m1_waitrequest_n) drive_req(1, 1'b0, 1'b0, '0, '0);
        end
        check("full_rd_blocked", 64'(saw_rd), 64'd0);
        check("full_wr_granted", 64'(saw_wr), 64'd1);
        bus.avl_readdata = 32'hBEEF; bus.avl_readdatavalid = 1'b1;
        tick();
        bus.avl_readdatavalid = 1'b0;
        check("full_ret_rdv0", 64'(bus.m0_readdatavalid), 64'd1);
        check("full_ret_data", 64'(bus.m_readdata), 64'hBEEF);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (bus.avl_read) begin
                found = 1'b1;
                check("full_5th_addr", 64'(bus.avl_address), 64'h55);
            end
        end
        check("full_5th_issued", 64'(found), 64'd1);
        tick();
        check("full_5th_ack", 64'(bus.m0_waitrequest_n), 64'd1);
        drive_req(0, 1'b0, 1'b0, '0, '0);
        tick();

        // Spurious readdatavalid with empty queue
        do_reset();
        bus.avl_readdata = 32'hDEAD; bus.avl_readdatavalid = 1'b1;
        tick();
        bus.avl_readdatavalid = 1'b0;
        check("sp_rdv0", 64'(bus.m0_readdatavalid), 64'd0);
        check("sp_rdv1", 64'(bus.m1_readdatavalid), 64'd0);
        check("sp_data", 64'(bus.m_readdata), 64'd0);
        check("sp_err",  64'(bus.err_unexpected_rdv), 64'd1);
        tick(); tick(); tick();
        check("sp_err_sticky", 64'(bus.err_unexpected_rdv), 64'd1);
        do_reset();
        check("sp_err_cleared", 64'(bus.err_unexpected_rdv), 64'd0);

        // Reset during CMD with 2 reads outstanding
        issue(0, 1'b1, 27'h31, '0, "pre_rd_a");
        issue(0, 1'b1, 27'h32, '0, "pre_rd_b");
        bus.avl_waitrequest_n = 1'b0;
        drive_req(1, 1'b0, 1'b1, 27'h333, 32'h3333);
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            tick();
            if (bus.avl_write) found = 1'b1;
        end
        check("mid_in_cmd", 64'(found), 64'd1);
        #2;
        iRST_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        drive_req(1, 1'b0, 1'b0, '0, '0);
        bus.avl_waitrequest_n = 1'b1;
        tick();
        tick();
        iRST_n = 1'b1;
        bus.avl_readdata = 32'h99; bus.avl_readdatavalid = 1'b1;
        tick();
        bus.avl_readdatavalid = 1'b0;
        check("mid_rdv0", 64'(bus.m0_readdatavalid), 64'd0);
        check("mid_rdv1", 64'(bus.m1_readdatavalid), 64'd0);
        check("mid_data", 64'(bus.m_readdata), 64'd0);
        check("mid_err",  64'(bus.err_unexpected_rdv), 64'd1);

        // local_init_done low blocks every grant
        bus.local_init_done = 1'b0;
        drive_req(0, 1'b1, 1'b0, 27'h1, '0);
        drive_req(1, 1'b0, 1'b1, 27'h2, 32'h2);
        saw_rd = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.avl_read || bus.avl_write || bus.m0_waitrequest_n || bus.m1_waitrequest_n)
                saw_rd = 1'b1;
        end
        check("init_blocks", 64'(saw_rd), 64'd0);
        bus.local_init_done = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            tick();
            if (bus.avl_read || bus.avl_write) begin
                found = 1'b1;
                check("init_first_rd",   64'(bus.avl_read), 64'd1);
                check("init_first_addr", 64'(bus.avl_address), 64'h1);
            end
        end
        check("init_resumes", 64'(found), 64'd1);
        drive_req(0, 1'b0, 1'b0, '0, '0);
        drive_req(1, 1'b0, 1'b0, '0, '0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
